// File: rtl/ps2_zx_pkg.sv
// Shared definitions for the PS/2 to ZX Spectrum keyboard matrix bridge:
// scan codes, decoder/receiver states and the set-2 to matrix mapping.
package ps2_zx_pkg;

    localparam logic [7:0] SC_EXT    = 8'hE0;
    localparam logic [7:0] SC_BRK    = 8'hF0;

    localparam logic [7:0] SC_LSHIFT = 8'h12;
    localparam logic [7:0] SC_RSHIFT = 8'h59;
    localparam logic [7:0] SC_LCTRL  = 8'h14;
    localparam logic [7:0] SC_ALT    = 8'h11;
    localparam logic [7:0] SC_DEL    = 8'h71;
    localparam logic [7:0] SC_BKSP   = 8'h66;

    localparam logic [7:0] SC_Z = 8'h1A, SC_X = 8'h22, SC_C = 8'h21, SC_V = 8'h2A;
    localparam logic [7:0] SC_A = 8'h1C, SC_S = 8'h1B, SC_D = 8'h23, SC_F = 8'h2B, SC_G = 8'h34;
    localparam logic [7:0] SC_Q = 8'h15, SC_W = 8'h1D, SC_E = 8'h24, SC_R = 8'h2D, SC_T = 8'h2C;
    localparam logic [7:0] SC_1 = 8'h16, SC_2 = 8'h1E, SC_3 = 8'h26, SC_4 = 8'h25, SC_5 = 8'h2E;
    localparam logic [7:0] SC_0 = 8'h45, SC_9 = 8'h46, SC_8 = 8'h3E, SC_7 = 8'h3D, SC_6 = 8'h36;
    localparam logic [7:0] SC_P = 8'h4D, SC_O = 8'h44, SC_I = 8'h43, SC_U = 8'h3C, SC_Y = 8'h35;
    localparam logic [7:0] SC_ENTER = 8'h5A, SC_L = 8'h4B, SC_K = 8'h42, SC_J = 8'h3B, SC_H = 8'h33;
    localparam logic [7:0] SC_SPACE = 8'h29, SC_M = 8'h3A, SC_N = 8'h31, SC_B = 8'h32;

    localparam logic [7:0] SC_F1  = 8'h05, SC_F2  = 8'h06, SC_F3  = 8'h04, SC_F4  = 8'h0C;
    localparam logic [7:0] SC_F5  = 8'h03, SC_F6  = 8'h0B, SC_F7  = 8'h83, SC_F8  = 8'h0A;
    localparam logic [7:0] SC_F9  = 8'h01, SC_F10 = 8'h09, SC_F11 = 8'h78, SC_F12 = 8'h07;

    localparam int unsigned MOD_ALT    = 0;
    localparam int unsigned MOD_CTRL_L = 1;
    localparam int unsigned MOD_CTRL_R = 2;
    localparam int unsigned MOD_DEL    = 3;
    localparam int unsigned MOD_NUM    = 4;

    typedef enum logic [1:0] {DEC_IDLE, DEC_E0, DEC_F0, DEC_E0F0} dec_state_t;
    typedef enum logic       {RX_IDLE, RX_FRAME} rx_state_t;

    typedef struct packed {
        logic       valid;
        logic       composite;
        logic [2:0] row;
        logic [2:0] col;
    } key_pos_t;

    function automatic key_pos_t kp(input int unsigned r, input int unsigned c);
        key_pos_t k;
        k.valid     = 1'b1;
        k.composite = 1'b0;
        k.row       = 3'(r);
        k.col       = 3'(c);
        return k;
    endfunction

    // Backspace reports row4/col0 with composite set; the caller adds CS itself.
    function automatic key_pos_t map_key(input logic ext, input logic [7:0] code);
        key_pos_t k;
        k = '0;
        if (!ext) begin
            case (code)
                SC_LSHIFT, SC_RSHIFT: k = kp(0, 0);
                SC_Z: k = kp(0, 1);  SC_X: k = kp(0, 2);  SC_C: k = kp(0, 3);  SC_V: k = kp(0, 4);
                SC_A: k = kp(1, 0);  SC_S: k = kp(1, 1);  SC_D: k = kp(1, 2);  SC_F: k = kp(1, 3);
                SC_G: k = kp(1, 4);
                SC_Q: k = kp(2, 0);  SC_W: k = kp(2, 1);  SC_E: k = kp(2, 2);  SC_R: k = kp(2, 3);
                SC_T: k = kp(2, 4);
                SC_1: k = kp(3, 0);  SC_2: k = kp(3, 1);  SC_3: k = kp(3, 2);  SC_4: k = kp(3, 3);
                SC_5: k = kp(3, 4);
                SC_0: k = kp(4, 0);  SC_9: k = kp(4, 1);  SC_8: k = kp(4, 2);  SC_7: k = kp(4, 3);
                SC_6: k = kp(4, 4);
                SC_P: k = kp(5, 0);  SC_O: k = kp(5, 1);  SC_I: k = kp(5, 2);  SC_U: k = kp(5, 3);
                SC_Y: k = kp(5, 4);
                SC_ENTER: k = kp(6, 0);  SC_L: k = kp(6, 1);  SC_K: k = kp(6, 2);  SC_J: k = kp(6, 3);
                SC_H: k = kp(6, 4);
                SC_SPACE: k = kp(7, 0);  SC_LCTRL: k = kp(7, 1);  SC_M: k = kp(7, 2);
                SC_N: k = kp(7, 3);  SC_B: k = kp(7, 4);
                SC_BKSP: begin
                    k = kp(4, 0);
                    k.composite = 1'b1;
                end
                default: k = '0;
            endcase
        end
        return k;
    endfunction

    // Returns 1..12 for F1..F12, 0 for anything else.
    function automatic logic [3:0] fkey_index(input logic ext, input logic [7:0] code);
        logic [3:0] idx;
        idx = 4'd0;
        if (!ext) begin
            case (code)
                SC_F1:  idx = 4'd1;   SC_F2:  idx = 4'd2;   SC_F3:  idx = 4'd3;
                SC_F4:  idx = 4'd4;   SC_F5:  idx = 4'd5;   SC_F6:  idx = 4'd6;
                SC_F7:  idx = 4'd7;   SC_F8:  idx = 4'd8;   SC_F9:  idx = 4'd9;
                SC_F10: idx = 4'd10;  SC_F11: idx = 4'd11;  SC_F12: idx = 4'd12;
                default: idx = 4'd0;
            endcase
        end
        return idx;
    endfunction

    function automatic logic [MOD_NUM-1:0] mod_mask(input logic ext, input logic [7:0] code);
        logic [MOD_NUM-1:0] m;
        m = '0;
        if (!ext && code == SC_ALT)   m[MOD_ALT]    = 1'b1;
        if (!ext && code == SC_LCTRL) m[MOD_CTRL_L] = 1'b1;
        if (ext  && code == SC_LCTRL) m[MOD_CTRL_R] = 1'b1;
        if (ext  && code == SC_DEL)   m[MOD_DEL]    = 1'b1;
        return m;
    endfunction

endpackage

// File: rtl/ps2_zx_matrix_rx.sv
// PS/2 device-to-host receiver: synchronisers, clock glitch filter,
// 11-bit frame capture with odd parity check and mid-frame timeout.
module ps2_rx
    import ps2_zx_pkg::*;
#(
    parameter int unsigned FILTER_LEN  = 8,
    parameter int unsigned TIMEOUT_CYC = 28000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] rx_byte,
    output logic       byte_valid,
    output logic       rx_err
);

    localparam int unsigned FW = $clog2(FILTER_LEN + 1);
    localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [FW-1:0] FLT_MAX = FW'(FILTER_LEN - 1);
    localparam logic [TW-1:0] TO_MAX  = TW'(TIMEOUT_CYC - 1);

    logic          clk_s1, clk_s2, dat_s1, dat_s2;
    logic          clk_f, clk_f_d;
    logic [FW-1:0] flt_cnt;
    logic          strobe;

    rx_state_t     rx_st;
    logic [3:0]    bit_cnt;
    logic [7:0]    shreg;
    logic          par;
    logic [TW-1:0] to_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clk_s1  <= 1'b1;
            clk_s2  <= 1'b1;
            dat_s1  <= 1'b1;
            dat_s2  <= 1'b1;
            clk_f   <= 1'b1;
            clk_f_d <= 1'b1;
            flt_cnt <= '0;
        end else begin
            clk_s1  <= ps2_clk;
            clk_s2  <= clk_s1;
            dat_s1  <= ps2_data;
            dat_s2  <= dat_s1;
            clk_f_d <= clk_f;
            // Level is accepted on the FILTER_LEN-th consecutive differing sample.
            if (clk_s2 == clk_f) begin
                flt_cnt <= '0;
            end else if (flt_cnt == FLT_MAX) begin
                clk_f   <= clk_s2;
                flt_cnt <= '0;
            end else begin
                flt_cnt <= flt_cnt + 1'b1;
            end
        end
    end

    assign strobe = clk_f_d & ~clk_f;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_st      <= RX_IDLE;
            bit_cnt    <= '0;
            shreg      <= '0;
            par        <= 1'b0;
            to_cnt     <= '0;
            rx_byte    <= '0;
            byte_valid <= 1'b0;
            rx_err     <= 1'b0;
        end else begin
            byte_valid <= 1'b0;
            rx_err     <= 1'b0;
            case (rx_st)
                RX_IDLE: begin
                    to_cnt <= '0;
                    if (strobe && !dat_s2) begin
                        rx_st   <= RX_FRAME;
                        bit_cnt <= '0;
                    end
                end
                RX_FRAME: begin
                    if (strobe) begin
                        to_cnt  <= '0;
                        bit_cnt <= bit_cnt + 1'b1;
                        if (bit_cnt < 4'd8) begin
                            shreg <= {dat_s2, shreg[7:1]};
                        end else if (bit_cnt == 4'd8) begin
                            par <= dat_s2;
                        end else begin
                            rx_st <= RX_IDLE;
                            if (dat_s2 && (^{shreg, par})) begin
                                byte_valid <= 1'b1;
                                rx_byte    <= shreg;
                            end else begin
                                rx_err <= 1'b1;
                            end
                        end
                    end else if (to_cnt == TO_MAX) begin
                        rx_st  <= RX_IDLE;
                        rx_err <= 1'b1;
                    end else begin
                        to_cnt <= to_cnt + 1'b1;
                    end
                end
                default: rx_st <= RX_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/ps2_zx_matrix.sv
// PS/2 set-2 scan-code decoder driving the ZX Spectrum 8x5 keyboard matrix,
// function-key levels and the Ctrl+Alt+Del reset request.
module ps2_zx_matrix
    import ps2_zx_pkg::*;
#(
    parameter int unsigned FILTER_LEN  = 8,
    parameter int unsigned TIMEOUT_CYC = 28000
) (
    input  logic        clk,
    input  logic        RESET_n,
    input  logic        ps2_clk,
    input  logic        ps2_data,
    input  logic [7:0]  zx_kb_scan,
    output logic [4:0]  zx_kb_out,
    output logic [12:1] f_key,
    output logic        res_k,
    output logic        rx_err
);

    logic [7:0]         rx_byte;
    logic               byte_valid;
    dec_state_t         state;
    logic               ev_make, ev_break, ev_ext;
    key_pos_t           kpos;
    logic [3:0]         fk;
    logic [MOD_NUM-1:0] mm;
    logic [MOD_NUM-1:0] mods;

    logic [4:0]         mat [8];
    logic [4:0]         eff [8];
    logic               shift_l, shift_r, bksp;
    logic [4:0]         col_any;

    ps2_rx #(
        .FILTER_LEN (FILTER_LEN),
        .TIMEOUT_CYC(TIMEOUT_CYC)
    ) u_rx (
        .clk       (clk),
        .rst_n     (RESET_n),
        .ps2_clk   (ps2_clk),
        .ps2_data  (ps2_data),
        .rx_byte   (rx_byte),
        .byte_valid(byte_valid),
        .rx_err    (rx_err)
    );

    always_comb begin
        ev_make  = 1'b0;
        ev_break = 1'b0;
        ev_ext   = 1'b0;
        if (byte_valid) begin
            case (state)
                DEC_IDLE: ev_make = (rx_byte != SC_EXT) && (rx_byte != SC_BRK);
                DEC_E0: begin
                    ev_make = (rx_byte != SC_BRK);
                    ev_ext  = 1'b1;
                end
                DEC_F0:   ev_break = 1'b1;
                DEC_E0F0: begin
                    ev_break = 1'b1;
                    ev_ext   = 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign kpos = map_key(ev_ext, rx_byte);
    assign fk   = fkey_index(ev_ext, rx_byte);
    assign mm   = mod_mask(ev_ext, rx_byte);

    always_ff @(posedge clk or negedge RESET_n) begin
        if (!RESET_n) begin
            state <= DEC_IDLE;
        end else if (rx_err) begin
            state <= DEC_IDLE;
        end else if (byte_valid) begin
            case (state)
                DEC_IDLE: begin
                    if (rx_byte == SC_EXT)      state <= DEC_E0;
                    else if (rx_byte == SC_BRK) state <= DEC_F0;
                end
                DEC_E0:  state <= (rx_byte == SC_BRK) ? DEC_E0F0 : DEC_IDLE;
                default: state <= DEC_IDLE;
            endcase
        end
    end

    // CS and "0" have extra sources (both shifts, Backspace) kept outside mat.
    always_ff @(posedge clk or negedge RESET_n) begin
        if (!RESET_n) begin
            for (int unsigned i = 0; i < 8; i++) mat[i] <= '0;
            shift_l <= 1'b0;
            shift_r <= 1'b0;
            bksp    <= 1'b0;
            f_key   <= '0;
            mods    <= '0;
        end else if (ev_make || ev_break) begin
            if (kpos.valid) begin
                if (kpos.composite)
                    bksp <= ev_make;
                else if (kpos.row == 3'd0 && kpos.col == 3'd0) begin
                    if (rx_byte == SC_RSHIFT) shift_r <= ev_make;
                    else                      shift_l <= ev_make;
                end else
                    mat[kpos.row][kpos.col] <= ev_make;
            end
            if (fk != 4'd0) f_key[fk] <= ev_make;
            mods <= ev_make ? (mods | mm) : (mods & ~mm);
        end
    end

    always_ff @(posedge clk or negedge RESET_n) begin
        if (!RESET_n)
            res_k <= 1'b1;
        else
            res_k <= ~(mods[MOD_ALT] & (mods[MOD_CTRL_L] | mods[MOD_CTRL_R]) & mods[MOD_DEL]);
    end

    always_comb begin
        for (int unsigned i = 0; i < 8; i++) eff[i] = mat[i];
        eff[0][0] = shift_l | shift_r | bksp;
        eff[4][0] = mat[4][0] | bksp;
    end

    always_comb begin
        col_any = '0;
        for (int unsigned i = 0; i < 8; i++)
            if (!zx_kb_scan[i]) col_any = col_any | eff[i];
        zx_kb_out = ~col_any;
    end

endmodule

// File: tb/tb_ps2_zx_matrix.sv
// Self-checking bench for ps2_zx_matrix: directed scenarios plus randomized
// key traffic compared against a held-key reference model.
module tb_ps2_zx_matrix;

    localparam int unsigned TO = 3000;
    localparam int unsigned H  = 20;

    logic        clk = 1'b0;
    logic        RESET_n = 1'b0;
    logic        ps2_clk = 1'b1;
    logic        ps2_data = 1'b1;
    logic [7:0]  zx_kb_scan = 8'hFF;
    logic [4:0]  zx_kb_out;
    logic [12:1] f_key;
    logic        res_k;
    logic        rx_err;

    int n_cmp = 0;
    int n_bad = 0;
    int err_pulses = 0;

    bit h0 [256];
    bit h1 [256];
    logic [7:0] key_tab [8][5];
    logic [7:0] fk_tab [12];
    int unsigned pool [$];

    ps2_zx_matrix #(
        .FILTER_LEN (8),
        .TIMEOUT_CYC(TO)
    ) dut (
        .clk       (clk),
        .RESET_n   (RESET_n),
        .ps2_clk   (ps2_clk),
        .ps2_data  (ps2_data),
        .zx_kb_scan(zx_kb_scan),
        .zx_kb_out (zx_kb_out),
        .f_key     (f_key),
        .res_k     (res_k),
        .rx_err    (rx_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (rx_err === 1'b1) err_pulses++;

    function automatic bit pressed(input int r, input int c);
        if (r == 0 && c == 0) return h0[8'h12] | h0[8'h59] | h0[8'h66];
        if (r == 4 && c == 0) return h0[8'h45] | h0[8'h66];
        return h0[key_tab[r][c]];
    endfunction

    function automatic logic [4:0] exp_out(input logic [7:0] scan);
        logic [4:0] r;
        r = 5'h1F;
        for (int i = 0; i < 8; i++)
            if (!scan[i])
                for (int c = 0; c < 5; c++)
                    if (pressed(i, c)) r[c] = 1'b0;
        return r;
    endfunction

    function automatic logic [12:1] exp_fkey();
        logic [12:1] e;
        for (int i = 0; i < 12; i++) e[i+1] = h0[fk_tab[i]];
        return e;
    endfunction

    function automatic logic exp_resk();
        return !(h0[8'h11] && (h0[8'h14] || h1[8'h14]) && h1[8'h71]);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_scan(input string tag, input logic [7:0] scan, input logic [4:0] exp);
        @(negedge clk);
        zx_kb_scan = scan;
        #1;
        chk(tag, {27'b0, zx_kb_out}, {27'b0, exp});
    endtask

    task automatic chk_model(input string tag);
        logic [7:0] s;
        chk_scan({tag, "_scan00"}, 8'h00, exp_out(8'h00));
        chk_scan({tag, "_scanFF"}, 8'hFF, exp_out(8'hFF));
        s = 8'($urandom);
        chk_scan({tag, "_scanR"}, s, exp_out(s));
        s = ~(8'h01 << $urandom_range(0, 7));
        chk_scan({tag, "_row"}, s, exp_out(s));
        chk({tag, "_fkey"}, {20'b0, f_key}, {20'b0, exp_fkey()});
        chk({tag, "_resk"}, {31'b0, res_k}, {31'b0, exp_resk()});
    endtask

    task automatic send_bits(input logic [10:0] bits, input int n);
        for (int i = 0; i < n; i++) begin
            ps2_data = bits[i];
            repeat (H) @(posedge clk);
            ps2_clk = 1'b0;
            repeat (H) @(posedge clk);
            ps2_clk = 1'b1;
        end
    endtask

    function automatic logic [10:0] frame(input logic [7:0] b, input logic bad_par);
        return {1'b1, (~^b) ^ bad_par, b, 1'b0};
    endfunction

    task automatic send_byte(input logic [7:0] b, input logic bad_par);
        send_bits(frame(b, bad_par), 11);
        ps2_data = 1'b1;
        repeat (2 * H) @(posedge clk);
    endtask

    task automatic key(input logic ext, input logic [7:0] code, input logic make);
        if (ext)   send_byte(8'hE0, 1'b0);
        if (!make) send_byte(8'hF0, 1'b0);
        send_byte(code, 1'b0);
        if (ext) h1[code] = make;
        else     h0[code] = make;
    endtask

    initial begin
        int e0;
        key_tab[0] = '{8'h12, 8'h1A, 8'h22, 8'h21, 8'h2A};
        key_tab[1] = '{8'h1C, 8'h1B, 8'h23, 8'h2B, 8'h34};
        key_tab[2] = '{8'h15, 8'h1D, 8'h24, 8'h2D, 8'h2C};
        key_tab[3] = '{8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E};
        key_tab[4] = '{8'h45, 8'h46, 8'h3E, 8'h3D, 8'h36};
        key_tab[5] = '{8'h4D, 8'h44, 8'h43, 8'h3C, 8'h35};
        key_tab[6] = '{8'h5A, 8'h4B, 8'h42, 8'h3B, 8'h33};
        key_tab[7] = '{8'h29, 8'h14, 8'h3A, 8'h31, 8'h32};
        fk_tab = '{8'h05, 8'h06, 8'h04, 8'h0C, 8'h03, 8'h0B, 8'h83, 8'h0A, 8'h01, 8'h09, 8'h78, 8'h07};
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 5; c++) pool.push_back({24'b0, key_tab[r][c]});
        pool.push_back(32'h59);
        pool.push_back(32'h66);
        pool.push_back(32'h11);
        for (int i = 0; i < 12; i++) pool.push_back({24'b0, fk_tab[i]});
        pool.push_back(32'h114);
        pool.push_back(32'h171);

        // Reset state
        repeat (5) @(posedge clk);
        chk_scan("rst_out", 8'h00, 5'h1F);
        chk("rst_fkey", {20'b0, f_key}, 32'h0);
        chk("rst_resk", {31'b0, res_k}, 32'h1);
        chk("rst_err", {31'b0, rx_err}, 32'h0);
        @(negedge clk);
        RESET_n = 1'b1;
        repeat (20) @(posedge clk);

        // A make / break
        key(1'b0, 8'h1C, 1'b1);
        chk_scan("a_make", 8'hFD, 5'h1E);
        key(1'b0, 8'h1C, 1'b0);
        chk_scan("a_break", 8'hFD, 5'h1F);

        // CS + Z on row 0, scan combinations
        key(1'b0, 8'h12, 1'b1);
        key(1'b0, 8'h1A, 1'b1);
        chk_scan("csz_FE", 8'hFE, 5'h1C);
        chk_scan("csz_00", 8'h00, 5'h1C);
        chk_scan("csz_FF", 8'hFF, 5'h1F);
        key(1'b0, 8'h12, 1'b0);
        key(1'b0, 8'h1A, 1'b0);
        chk_model("csz_rel");

        // Bad parity: one error pulse, matrix unchanged
        e0 = err_pulses;
        send_byte(8'h1C, 1'b1);
        chk("par_err", err_pulses - e0, 1);
        chk_scan("par_mat", 8'hFD, 5'h1F);

        // Truncated frame: timeout error, then normal decode resumes
        e0 = err_pulses;
        send_bits(frame(8'h1C, 1'b0), 4);
        ps2_data = 1'b1;
        repeat (TO / 2) @(posedge clk);
        chk("to_early", err_pulses - e0, 0);
        repeat (TO / 2 + 100) @(posedge clk);
        chk("to_err", err_pulses - e0, 1);
        key(1'b0, 8'h1C, 1'b1);
        chk_scan("to_after", 8'hFD, 5'h1E);
        key(1'b0, 8'h1C, 1'b0);

        // Function keys
        key(1'b0, 8'h01, 1'b1);
        chk("f9_make", {31'b0, f_key[9]}, 32'h1);
        key(1'b0, 8'h01, 1'b0);
        chk("f9_break", {31'b0, f_key[9]}, 32'h0);
        key(1'b0, 8'h07, 1'b1);
        chk("f12_make", {20'b0, f_key}, 32'h800);

        // Ctrl+Alt+Del
        key(1'b0, 8'h14, 1'b1);
        key(1'b0, 8'h11, 1'b1);
        chk("res_partial", {31'b0, res_k}, 32'h1);
        key(1'b1, 8'h71, 1'b1);
        chk("res_hold", {31'b0, res_k}, 32'h0);
        key(1'b1, 8'h71, 1'b0);
        chk("res_rel", {31'b0, res_k}, 32'h1);
        key(1'b0, 8'h14, 1'b0);
        key(1'b0, 8'h11, 1'b0);

        // Backspace composite with shift held
        key(1'b0, 8'h12, 1'b1);
        key(1'b0, 8'h66, 1'b1);
        chk_scan("bs_cs", 8'hFE, 5'h1E);
        chk_scan("bs_zero", 8'hEF, 5'h1E);
        key(1'b0, 8'h66, 1'b0);
        chk_scan("bs_rel_cs", 8'hFE, 5'h1E);
        chk_scan("bs_rel_zero", 8'hEF, 5'h1F);
        chk_model("bs_model");

        // Random key traffic against the model
        for (int it = 0; it < 30; it++) begin
            int unsigned p;
            p = pool[$urandom_range(0, pool.size() - 1)];
            key(p[8], p[7:0], 1'($urandom_range(0, 1)));
            chk_model("rnd");
        end

        // Reset in the middle of a frame, with keys held
        key(1'b0, 8'h12, 1'b1);
        key(1'b0, 8'h07, 1'b1);
        send_bits(frame(8'h1C, 1'b0), 5);
        RESET_n = 1'b0;
        #1;
        chk("mrst_out", {27'b0, zx_kb_out}, 32'h1F);
        chk("mrst_fkey", {20'b0, f_key}, 32'h0);
        chk("mrst_resk", {31'b0, res_k}, 32'h1);
        chk("mrst_err", {31'b0, rx_err}, 32'h0);
        for (int i = 0; i < 256; i++) begin
            h0[i] = 1'b0;
            h1[i] = 1'b0;
        end
        ps2_data = 1'b1;
        repeat (5) @(posedge clk);
        @(negedge clk);
        RESET_n = 1'b1;
        repeat (20) @(posedge clk);
        key(1'b0, 8'h1C, 1'b1);
        chk_scan("mrst_after", 8'hFD, 5'h1E);
        chk_model("final");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
